// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - shared types and constants for the program counter stack
package pc_pkg;

    localparam int PC_XLEN_MAX = 64;
    localparam int INSN_BYTES  = 4;

    typedef logic [PC_XLEN_MAX-1:0] pc_t;

    typedef enum logic [1:0] {
        PC_SYS,
        PC_JUMP,
        PC_SEQ,
        PC_HOLD
    } pc_src_e;

    // Trap redirect beats a normal jump, which beats sequential retire.
    function automatic pc_src_e next_source(input logic system_jump,
                                            input logic jump,
                                            input logic write);
        if (system_jump)
            return PC_SYS;
        else if (jump)
            return PC_JUMP;
        else if (write)
            return PC_SEQ;
        else
            return PC_HOLD;
    endfunction

endpackage

// File: rtl/program_counter_stack_if.sv
// rtl/program_counter_stack_if.sv - control/address bundle between control unit and program counter stack
interface program_counter_stack_if #(
    parameter int XLEN = 32
);
    logic            write;
    logic            jump;
    logic            pc_relative;
    logic            use_offset;
    logic            forward_address;
    logic [XLEN-1:0] immediate;
    logic [XLEN-1:0] address_in;
    logic            system_jump;
    logic            system_load;
    logic [XLEN-1:0] system_address_target;
    logic            call;
    logic            ret;
    logic            ras_flush;

    logic [1:0]      data_offset;
    logic [XLEN-1:0] calculated_address;
    logic [XLEN-1:0] next;
    logic [XLEN-1:0] current;
    logic [XLEN-1:0] last;
    logic [XLEN-1:0] address_bus;
    logic            misaligned;
    logic            ras_mismatch;
    logic            ras_empty;
    logic            ras_full;
    logic [XLEN-1:0] ras_top;

    modport master (
        output write, jump, pc_relative, use_offset, forward_address,
               immediate, address_in, system_jump, system_load,
               system_address_target, call, ret, ras_flush,
        input  data_offset, calculated_address, next, current, last,
               address_bus, misaligned, ras_mismatch, ras_empty, ras_full, ras_top
    );

    modport slave (
        input  write, jump, pc_relative, use_offset, forward_address,
               immediate, address_in, system_jump, system_load,
               system_address_target, call, ret, ras_flush,
        output data_offset, calculated_address, next, current, last,
               address_bus, misaligned, ras_mismatch, ras_empty, ras_full, ras_top
    );
endinterface

// File: rtl/program_counter_stack_return_stack.sv
// rtl/program_counter_stack_return_stack.sv - circular return-address LIFO with flush
module return_stack #(
    parameter int WIDTH = 30,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] top,
    output logic             empty,
    output logic             full
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] ptr;
    logic [PTR_W:0]   count;
    logic [PTR_W-1:0] top_idx;
    logic [PTR_W-1:0] wr_idx;

    assign top_idx = ptr - PTR_W'(1);
    assign empty   = (count == '0);
    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign top     = empty ? '0 : mem[top_idx];
    // Simultaneous push/pop on a non-empty stack replaces the top in place.
    assign wr_idx  = (pop && !empty) ? top_idx : ptr;

    always_ff @(posedge clock) begin
        if (push && !flush)
            mem[wr_idx] <= push_data;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ptr   <= '0;
            count <= '0;
        end else if (flush) begin
            ptr   <= '0;
            count <= '0;
        end else if (push && pop) begin
            if (empty) begin
                ptr   <= ptr + PTR_W'(1);
                count <= (PTR_W+1)'(1);
            end
        end else if (push) begin
            // When full the pointer wraps onto the oldest entry.
            ptr <= ptr + PTR_W'(1);
            if (!full)
                count <= count + (PTR_W+1)'(1);
        end else if (pop && !empty) begin
            ptr   <= top_idx;
            count <= count - (PTR_W+1)'(1);
        end
    end
endmodule

// File: rtl/program_counter_stack.sv
// rtl/program_counter_stack.sv - PC triple, address generation and optional return-address stack (PC_RAS_EN)
module program_counter_stack
    import pc_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter int              ALIGN_BITS   = 2,
    parameter int              RAS_DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
    input logic                    clock,
    input logic                    reset,
    program_counter_stack_if.slave pcs
);
    localparam int            PW       = XLEN - ALIGN_BITS;
    localparam logic [PW-1:0] RESET_PC = RESET_VECTOR[XLEN-1:ALIGN_BITS];
    localparam logic [PW-1:0] SEQ_STEP = PW'(INSN_BYTES >> ALIGN_BITS);

    logic [PW-1:0]   next_q;
    logic [PW-1:0]   current_q;
    logic [PW-1:0]   last_q;
    logic [1:0]      data_offset_q;
    logic            misaligned_q;
    logic [XLEN-1:0] next_ext;
    logic [XLEN-1:0] current_ext;
    logic [XLEN-1:0] base;
    logic [XLEN-1:0] calc;
    logic [PW-1:0]   calc_pc;
    pc_src_e         src;

    assign next_ext    = {next_q, {ALIGN_BITS{1'b0}}};
    assign current_ext = {current_q, {ALIGN_BITS{1'b0}}};
    assign base        = pcs.pc_relative ? current_ext : pcs.address_in;
    assign calc        = base + pcs.immediate;
    assign calc_pc     = calc[XLEN-1:ALIGN_BITS];
    assign src         = next_source(pcs.system_jump, pcs.jump, pcs.write);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            next_q        <= RESET_PC;
            current_q     <= RESET_PC;
            last_q        <= RESET_PC;
            data_offset_q <= '0;
            misaligned_q  <= 1'b0;
        end else begin
            case (src)
                PC_SYS:  next_q <= pcs.system_address_target[XLEN-1:ALIGN_BITS];
                PC_JUMP: next_q <= calc_pc;
                PC_SEQ:  next_q <= next_q + SEQ_STEP;
                default: next_q <= next_q;
            endcase
            if (pcs.write) begin
                last_q    <= current_q;
                current_q <= next_q;
            end
            if (pcs.forward_address)
                data_offset_q <= calc[1:0];
            misaligned_q <= pcs.jump && !pcs.system_jump && (calc[ALIGN_BITS-1:0] != '0);
        end
    end

    always_comb begin
        if (!pcs.forward_address)
            pcs.address_bus = next_ext;
        else if (pcs.system_load)
            pcs.address_bus = pcs.system_address_target;
        else if (pcs.use_offset)
            pcs.address_bus = calc;
        else
            pcs.address_bus = {calc[XLEN-1:2], 2'b00};
    end

    assign pcs.calculated_address = calc;
    assign pcs.next               = next_ext;
    assign pcs.current            = current_ext;
    assign pcs.last               = {last_q, {ALIGN_BITS{1'b0}}};
    assign pcs.data_offset        = data_offset_q;
    assign pcs.misaligned         = misaligned_q;

`ifdef PC_RAS_EN
    logic          ras_push;
    logic          ras_pop;
    logic [PW-1:0] top_pc;
    logic          stack_empty;
    logic          stack_full;
    logic          mismatch_q;

    assign ras_push = pcs.jump && pcs.call && !pcs.system_jump;
    assign ras_pop  = pcs.jump && pcs.ret && !pcs.system_jump;

    return_stack #(
        .WIDTH (PW),
        .DEPTH (RAS_DEPTH)
    ) u_return_stack (
        .clock     (clock),
        .reset     (reset),
        .flush     (pcs.ras_flush),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (next_q),
        .top       (top_pc),
        .empty     (stack_empty),
        .full      (stack_full)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            mismatch_q <= 1'b0;
        else if (pcs.ras_flush)
            mismatch_q <= 1'b0;
        else if (ras_pop && (stack_empty || top_pc != calc_pc))
            mismatch_q <= 1'b1;
    end

    assign pcs.ras_mismatch = mismatch_q;
    assign pcs.ras_empty    = stack_empty;
    assign pcs.ras_full     = stack_full;
    assign pcs.ras_top      = {top_pc, {ALIGN_BITS{1'b0}}};
`else
    logic unused_ras_inputs;
    assign unused_ras_inputs = ^{pcs.call, pcs.ret, pcs.ras_flush, RAS_DEPTH[0]};

    assign pcs.ras_mismatch = 1'b0;
    assign pcs.ras_empty    = 1'b1;
    assign pcs.ras_full     = 1'b0;
    assign pcs.ras_top      = '0;
`endif
endmodule
